// File: rtl/enc_stage_1.sv
// First encoder stage: Hamming check bits over a mode-sized info word, registered valid/ready output with a 1-entry skid.
// Optional build macro ENC_STAGE1_RANGE_CHECK_EN enables the err_range check on unused info bits.
module enc_stage_1 #(
    parameter int MAX_CODEWORD_WIDTH = 32,
    parameter int MAX_INFO_WIDTH     = 26
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [MAX_INFO_WIDTH-1:0]     info_in,
    input  logic [1:0]                    work_mod_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [MAX_CODEWORD_WIDTH-1:0] data_out,
    output logic [1:0]                    work_mod_out,
    output logic                          err_illegal,
    output logic                          err_range
);

    // Check-bit masks per mode, indexed by check-bit position
    localparam logic [3:0]  M00_P2 = 4'hE;
    localparam logic [3:0]  M00_P1 = 4'hD;
    localparam logic [3:0]  M00_P0 = 4'hB;
    localparam logic [10:0] M01_P3 = 11'h7F0;
    localparam logic [10:0] M01_P2 = 11'h78E;
    localparam logic [10:0] M01_P1 = 11'h66D;
    localparam logic [10:0] M01_P0 = 11'h55B;
    localparam logic [25:0] M10_P4 = 26'h3FFF800;
    localparam logic [25:0] M10_P3 = 26'h3FC07F0;
    localparam logic [25:0] M10_P2 = 26'h3C3C78E;
    localparam logic [25:0] M10_P1 = 26'h333366D;
    localparam logic [25:0] M10_P0 = 26'h2AAAD5B;

    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_FULL  = 2'b01,
        S_SKID  = 2'b10
    } state_t;

    state_t r_state, w_state_nxt;

    logic [31:0] w_cw;
    logic        w_legal;
    logic        w_take;
    logic        w_acc;
    logic        w_drain;
    logic        w_ld_out;
    logic        w_ld_skid;
    logic        w_skid2out;

    logic        r_in_ready;
    logic [31:0] r_out_data;
    logic [1:0]  r_out_mod;
    logic [31:0] r_skid_data;
    logic [1:0]  r_skid_mod;
    logic        r_err_illegal;

    // Encoder: slicing info to the mode's width masks the unused high bits.
    // The overall-parity slot is a constant 0 for the next stage to fill.
    always_comb begin
        w_cw    = '0;
        w_legal = 1'b1;
        case (work_mod_in)
            2'b00: w_cw = {24'b0, info_in[3:0], 1'b0,
                           ^(info_in[3:0] & M00_P2),
                           ^(info_in[3:0] & M00_P1),
                           ^(info_in[3:0] & M00_P0)};
            2'b01: w_cw = {16'b0, info_in[10:0], 1'b0,
                           ^(info_in[10:0] & M01_P3),
                           ^(info_in[10:0] & M01_P2),
                           ^(info_in[10:0] & M01_P1),
                           ^(info_in[10:0] & M01_P0)};
            2'b10: w_cw = {info_in[25:0], 1'b0,
                           ^(info_in & M10_P4),
                           ^(info_in & M10_P3),
                           ^(info_in & M10_P2),
                           ^(info_in & M10_P1),
                           ^(info_in & M10_P0)};
            default: w_legal = 1'b0;
        endcase
    end

    // Illegal-mode words are consumed but never enter the pipeline
    assign w_take  = in_valid & r_in_ready;
    assign w_acc   = w_take & w_legal;
    assign w_drain = (r_state != S_EMPTY) & out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_EMPTY;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ld_out    = 1'b0;
        w_ld_skid   = 1'b0;
        w_skid2out  = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_acc) begin
                    w_state_nxt = S_FULL;
                    w_ld_out    = 1'b1;
                end
            end
            S_FULL: begin
                if (w_acc && w_drain) begin
                    w_ld_out = 1'b1;
                end else if (w_acc) begin
                    w_state_nxt = S_SKID;
                    w_ld_skid   = 1'b1;
                end else if (w_drain) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            S_SKID: begin
                if (w_drain) begin
                    w_state_nxt = S_FULL;
                    w_skid2out  = 1'b1;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in_ready    <= 1'b1;
            r_out_data    <= '0;
            r_out_mod     <= '0;
            r_skid_data   <= '0;
            r_skid_mod    <= '0;
            r_err_illegal <= 1'b0;
        end else begin
            r_in_ready    <= (w_state_nxt != S_SKID);
            r_err_illegal <= w_take & ~w_legal;
            if (w_ld_out) begin
                r_out_data <= w_cw;
                r_out_mod  <= work_mod_in;
            end else if (w_skid2out) begin
                r_out_data <= r_skid_data;
                r_out_mod  <= r_skid_mod;
            end
            if (w_ld_skid) begin
                r_skid_data <= w_cw;
                r_skid_mod  <= work_mod_in;
            end
        end
    end

`ifdef ENC_STAGE1_RANGE_CHECK_EN
    logic w_range;
    logic r_err_range;

    always_comb begin
        w_range = 1'b0;
        case (work_mod_in)
            2'b00:   w_range = |info_in[25:4];
            2'b01:   w_range = |info_in[25:11];
            default: w_range = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_err_range <= 1'b0;
        else      r_err_range <= w_acc & w_range;
    end

    assign err_range = r_err_range;
`else
    assign err_range = 1'b0;
`endif

    assign in_ready     = r_in_ready;
    assign out_valid    = (r_state != S_EMPTY);
    assign data_out     = r_out_data;
    assign work_mod_out = r_out_mod;
    assign err_illegal  = r_err_illegal;

endmodule

// File: tb/tb_enc_stage_1.sv
// Directed bench for enc_stage_1: encoding vectors, backpressure/skid ordering, illegal mode, mid-flight reset.
module tb_enc_stage_1;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [25:0] info_in;
    logic [1:0]  work_mod_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_out;
    logic [1:0]  work_mod_out;
    logic        err_illegal;
    logic        err_range;

    int n_checks = 0;
    int n_errors = 0;

    enc_stage_1 dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .info_in      (info_in),
        .work_mod_in  (work_mod_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .data_out     (data_out),
        .work_mod_out (work_mod_out),
        .err_illegal  (err_illegal),
        .err_range    (err_range)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Offer one word with out_ready=1, check it one cycle later, then let it drain
    task automatic send(input string tag, input logic [1:0] mode, input logic [25:0] info,
                        input logic [31:0] exp);
        in_valid = 1'b1; work_mod_in = mode; info_in = info;
        step();
        in_valid = 1'b0;
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, data_out, exp);
        check({tag, "_mode"}, 32'(work_mod_out), 32'(mode));
        step();
        check({tag, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; info_in = '0; work_mod_in = 2'b00; out_ready = 1'b1;
        step(); step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_data", data_out, 32'h0);
        rst = 1'b1;
        step();
        check("rel_in_ready", 32'(in_ready), 32'd1);
        check("rel_out_valid", 32'(out_valid), 32'd0);
        check("rel_mode", 32'(work_mod_out), 32'd0);
        check("rel_err_ill", 32'(err_illegal), 32'd0);
        check("rel_err_rng", 32'(err_range), 32'd0);

        // Encoding vectors; modes alternate word to word
        send("t1", 2'b00, 26'hB,   32'h000000B1);
        send("t2", 2'b01, 26'h7FF, 32'h0000FFEF);
        send("t3a", 2'b10, 26'h1,  32'h00000043);
        send("t3b", 2'b10, 26'h0,  32'h00000000);
        send("t3c", 2'b00, 26'h2,  32'h00000025);

        // Backpressure: fill out reg and skid, third word must wait
        out_ready = 1'b0;
        in_valid = 1'b1; work_mod_in = 2'b00; info_in = 26'h1;
        step();
        check("t4_rdy1", 32'(in_ready), 32'd1);
        check("t4_w1", data_out, 32'h00000013);
        work_mod_in = 2'b00; info_in = 26'h2;
        step();
        check("t4_rdy2", 32'(in_ready), 32'd0);
        check("t4_hold", data_out, 32'h00000013);
        work_mod_in = 2'b01; info_in = 26'h1;
        step();
        check("t4_stall_rdy", 32'(in_ready), 32'd0);
        check("t4_stall_data", data_out, 32'h00000013);
        out_ready = 1'b1;
        step();
        check("t4_w2", data_out, 32'h00000025);
        check("t4_w2_mode", 32'(work_mod_out), 32'd0);
        check("t4_rdy_back", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("t4_w3", data_out, 32'h00000023);
        check("t4_w3_mode", 32'(work_mod_out), 32'd1);
        check("t4_w3_valid", 32'(out_valid), 32'd1);
        step();
        check("t4_empty", 32'(out_valid), 32'd0);

        // Illegal mode is swallowed
        in_valid = 1'b1; work_mod_in = 2'b11; info_in = 26'h5;
        step();
        in_valid = 1'b0;
        check("t5_ill_pulse", 32'(err_illegal), 32'd1);
        check("t5_ill_novalid", 32'(out_valid), 32'd0);
        step();
        check("t5_ill_clear", 32'(err_illegal), 32'd0);
        check("t5_ill_novalid2", 32'(out_valid), 32'd0);

        // Out-of-range info bits are masked
        in_valid = 1'b1; work_mod_in = 2'b00; info_in = 26'h10;
        step();
        in_valid = 1'b0;
        check("t5_rng_data", data_out, 32'h0);
        check("t5_rng_valid", 32'(out_valid), 32'd1);
`ifdef ENC_STAGE1_RANGE_CHECK_EN
        check("t5_rng_flag", 32'(err_range), 32'd1);
`else
        check("t5_rng_flag", 32'(err_range), 32'd0);
`endif
        step();
        check("t5_rng_clear", 32'(err_range), 32'd0);

        // Reset while holding two words
        out_ready = 1'b0;
        in_valid = 1'b1; work_mod_in = 2'b01; info_in = 26'h7FF;
        step();
        info_in = 26'h1;
        step();
        in_valid = 1'b0;
        check("t6_skid_rdy", 32'(in_ready), 32'd0);
        #2 rst = 1'b0;
        #1;
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        step();
        rst = 1'b1;
        out_ready = 1'b1;
        step();
        check("t6_rel_rdy", 32'(in_ready), 32'd1);
        check("t6_rel_valid", 32'(out_valid), 32'd0);
        send("t6_after", 2'b00, 26'hB, 32'h000000B1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
